// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode constants, hazard FSM state encoding
// and the decode helper telling whether an instruction reads its rt field.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hazard_state_t;

    // LW writes rt rather than reading it, so only these three read rt.
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_unit_load_use_detect.sv
// Combinational load-use detector: flags when the LW in EX writes a register
// the instruction in ID is about to read. r0 is never a real dependency.
module load_use_detect
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       load_use
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt == rs);
    assign rt_match = uses_rt(opcode) && (ex_rt == rt);

    assign load_use = ex_mem_read && (ex_rt != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall and branch flush controller beside the ID stage.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       if_id_opcode,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             hazard_detected,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] STALL_INIT = 2'(STALL_CYCLES - 1);

    hazard_state_t state, next_state;
    logic [1:0]    cnt, next_cnt;
    logic [4:0]    held_rt;
    logic          load_use;
    logic          enter_stall;

    load_use_detect u_load_use_detect (
        .opcode      (if_id_opcode),
        .rs          (if_id_rs),
        .rt          (if_id_rt),
        .ex_mem_read (id_ex_mem_read),
        .ex_rt       (id_ex_rt),
        .load_use    (load_use)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (enter_stall) begin
            held_rt <= id_ex_rt;
        end
    end

    // The first bubble is issued from IDLE; STALL covers the remaining ones.
    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        enter_stall = 1'b0;
        case (state)
            IDLE: begin
                if (!branch_taken && load_use && (STALL_CYCLES > 1)) begin
                    next_state  = STALL;
                    next_cnt    = STALL_INIT;
                    enter_stall = 1'b1;
                end
            end
            STALL: begin
                if (branch_taken || (cnt <= 2'd1)) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt - 2'd1;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Outputs react to the current inputs so a stall or flush lands this cycle.
    always_comb begin
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        hazard_detected = 1'b0;
        flush_if_id     = 1'b0;
        flush_id_ex     = 1'b0;
        flush_ex_mem    = 1'b0;
        if (!reset) begin
            if (branch_taken) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end else if ((state == STALL) || load_use) begin
                hazard_detected = 1'b1;
                pc_write        = 1'b0;
                if_id_write     = 1'b0;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hazard_detected) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (branch_taken && flush_ex_mem) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

    // A stall is only ever entered for a real (non-r0) destination.
    held_rt_nonzero: assert property (@(posedge clk) disable iff (reset)
        (state == STALL) |-> (held_rt != 5'd0));

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: three instances (stall depth 1, 2, 3; the
// last with 3-bit counters) share randomized stimulus checked against a model.
module tb_hazard_unit;

    typedef struct packed {
        logic        pc_write;
        logic        if_id_write;
        logic        hazard;
        logic        fl_if_id;
        logic        fl_id_ex;
        logic        fl_ex_mem;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
    } obs_t;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0;
    logic [4:0] rs = '0, rt = '0, ex_rt = '0;
    logic       mr = 1'b0, br = 1'b0;

    always #5 clk = ~clk;

    logic        pcw0, ifw0, hz0, fa0, fb0, fc0_o;
    logic        pcw1, ifw1, hz1, fa1, fb1, fc1_o;
    logic        pcw2, ifw2, hz2, fa2, fb2, fc2_o;
    logic [31:0] sc0, fcnt0, sc1, fcnt1;
    logic [2:0]  sc2, fcnt2;

    hazard_unit #(.STALL_CYCLES(1), .CNT_W(32)) u_s1 (
        .clk(clk), .reset(reset), .if_id_opcode(op), .if_id_rs(rs), .if_id_rt(rt),
        .id_ex_mem_read(mr), .id_ex_rt(ex_rt), .branch_taken(br),
        .pc_write(pcw0), .if_id_write(ifw0), .hazard_detected(hz0),
        .flush_if_id(fa0), .flush_id_ex(fb0), .flush_ex_mem(fc0_o),
        .stall_count(sc0), .flush_count(fcnt0));

    hazard_unit #(.STALL_CYCLES(2), .CNT_W(32)) u_s2 (
        .clk(clk), .reset(reset), .if_id_opcode(op), .if_id_rs(rs), .if_id_rt(rt),
        .id_ex_mem_read(mr), .id_ex_rt(ex_rt), .branch_taken(br),
        .pc_write(pcw1), .if_id_write(ifw1), .hazard_detected(hz1),
        .flush_if_id(fa1), .flush_id_ex(fb1), .flush_ex_mem(fc1_o),
        .stall_count(sc1), .flush_count(fcnt1));

    hazard_unit #(.STALL_CYCLES(3), .CNT_W(3)) u_s3 (
        .clk(clk), .reset(reset), .if_id_opcode(op), .if_id_rs(rs), .if_id_rt(rt),
        .id_ex_mem_read(mr), .id_ex_rt(ex_rt), .branch_taken(br),
        .pc_write(pcw2), .if_id_write(ifw2), .hazard_detected(hz2),
        .flush_if_id(fa2), .flush_id_ex(fb2), .flush_ex_mem(fc2_o),
        .stall_count(sc2), .flush_count(fcnt2));

    obs_t act0, act1, act2;
    assign act0 = {pcw0, ifw0, hz0, fa0, fb0, fc0_o, sc0, fcnt0};
    assign act1 = {pcw1, ifw1, hz1, fa1, fb1, fc1_o, sc1, fcnt1};
    assign act2 = {pcw2, ifw2, hz2, fa2, fb2, fc2_o, 29'd0, sc2, 29'd0, fcnt2};

    obs_t q0[$], q1[$], q2[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: remaining bubbles and counter totals per instance.
    int     depth[3] = '{1, 2, 3};
    int     cw[3]    = '{32, 32, 3};
    int     rem[3]   = '{0, 0, 0};
    longint scm[3]   = '{0, 0, 0};
    longint fcm[3]   = '{0, 0, 0};

    function automatic longint sat_ref(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic check(input int d, input obs_t a, input obs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL dut_s%0d t=%0t actual=%h required=%h", d + 1, $time, a, e);
        end
    endtask

    always @(negedge clk) begin
        obs_t e;
        if (q0.size() > 0) begin e = q0.pop_front(); check(0, act0, e); end
        if (q1.size() > 0) begin e = q1.pop_front(); check(1, act1, e); end
        if (q2.size() > 0) begin e = q2.pop_front(); check(2, act2, e); end
    end

    task automatic drive(input logic [5:0] o, input logic [4:0] a, input logic [4:0] b,
                         input logic m, input logic [4:0] er, input logic bt, input logic r);
        logic lu;
        obs_t e;
        @(posedge clk);
        #1;
        op = o; rs = a; rt = b; mr = m; ex_rt = er; br = bt; reset = r;
        lu = m && (er != 5'd0) &&
             ((er == a) || ((o inside {6'b000000, 6'b000100, 6'b101011}) && (er == b)));
        for (int d = 0; d < 3; d++) begin
            e = '0;
            e.pc_write    = 1'b1;
            e.if_id_write = 1'b1;
            if (r) begin
                rem[d] = 0;
                scm[d] = 0;
                fcm[d] = 0;
            end else begin
                e.stall_cnt = STATS ? 32'(scm[d]) : 32'd0;
                e.flush_cnt = STATS ? 32'(fcm[d]) : 32'd0;
                if (bt) begin
                    e.fl_if_id  = 1'b1;
                    e.fl_id_ex  = 1'b1;
                    e.fl_ex_mem = 1'b1;
                    rem[d] = 0;
                    fcm[d] = sat_ref(fcm[d], cw[d]);
                end else if (rem[d] > 0 || lu) begin
                    e.hazard      = 1'b1;
                    e.pc_write    = 1'b0;
                    e.if_id_write = 1'b0;
                    rem[d] = (rem[d] > 0) ? rem[d] - 1 : depth[d] - 1;
                    scm[d] = sat_ref(scm[d], cw[d]);
                end
            end
            case (d)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [5:0] ro;
        // reset held while a load-use is presented: outputs must stay default
        drive(6'b000000, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b1);
        drive(6'b000000, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b1);
        // LW r5 ; ADD r6,r5,r7 then the load moves on
        drive(6'b000000, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0);
        drive(6'b000000, 5'd5, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(3);
        // rt match with LW in ID: no stall; SW in ID: stall; r0 destination: none
        drive(6'b100011, 5'd8, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        idle(3);
        drive(6'b101011, 5'd8, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        idle(3);
        drive(6'b000000, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        // branch coincident with load-use
        drive(6'b000000, 5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0);
        idle(1);
        // branch on the second stall cycle
        drive(6'b000000, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0);
        drive(6'b000000, 5'd5, 5'd7, 1'b0, 5'd0, 1'b1, 1'b0);
        idle(2);
        // back-to-back loads keep re-arming the stall
        for (int i = 0; i < 5; i++) drive(6'b000100, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
        idle(3);
        // fresh counters: 3 stalls, 2 flushes, then reset mid-stall
        drive(6'b000000, 5'd1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(6'b000000, 5'd4, 5'd2, 1'b1, 5'd4, 1'b0, 1'b0);
            idle(3);
        end
        drive(6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        drive(6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        drive(6'b000000, 5'd4, 5'd2, 1'b1, 5'd4, 1'b0, 1'b0);
        drive(6'b000000, 5'd4, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(2);
        // randomized traffic over a small register set to provoke matches
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 5))
                0: ro = 6'b000000;
                1: ro = 6'b100011;
                2: ro = 6'b101011;
                3: ro = 6'b000100;
                4: ro = 6'b001000;
                default: ro = 6'($urandom);
            endcase
            drive(ro, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0));
        end
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
